// File: rtl/writeback_arb.sv
// writeback_arb: two-source register-file writeback arbiter.
// Per-source FIFOs with a round-robin grant, one registered write per cycle.
//
// Ports:
//   clk                       sole clock, rising edge
//   reset                     synchronous, active-low
//   alu_valid/alu_rd/alu_val  ALU result offer
//   alu_ready                 ALU queue not full (and out of reset)
//   mem_valid/mem_rd/mem_val  load result offer
//   mem_ready                 MEM queue not full (and out of reset)
//   write_sig/reg/val         registered register-file write port
//   idle                      both queues empty and no write in flight
//   wb_count                  committed-write counter (WB_COUNT_EN only)
//
// Build option: define WB_COUNT_EN to add the 32-bit wb_count output.

module writeback_arb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [63:0] alu_val,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [63:0] mem_val,
    output logic        mem_ready,
    output logic        write_sig,
    output logic [4:0]  write_reg,
    output logic [63:0] write_val,
    output logic        idle
`ifdef WB_COUNT_EN
    ,
    output logic [31:0] wb_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] val;
    } wb_entry_t;

    // Source index 0 is the ALU, index 1 is the load unit.
    logic      [1:0] src_valid;
    logic      [1:0] src_ready;
    logic      [1:0] push;
    logic      [1:0] pop;
    logic      [1:0] not_empty;
    logic      [1:0] full;
    wb_entry_t       src_in [2];
    wb_entry_t       head   [2];

    // Set on the first edge with reset released; holds ready low until
    // that edge so no transfer can land while the block is still resetting.
    logic run;

    logic      grant_alu;
    logic      grant_mem;
    logic      grant_any;
    logic      last_mem;
    wb_entry_t granted;

    assign src_valid = {mem_valid, alu_valid};

    assign src_in[0] = '{rd: alu_rd, val: alu_val};
    assign src_in[1] = '{rd: mem_rd, val: mem_val};

    assign alu_ready = src_ready[0];
    assign mem_ready = src_ready[1];

    for (genvar s = 0; s < 2; s++) begin : g_queue
        wb_entry_t     slots [DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [CW-1:0] count;

        assign full[s]      = (count == FULL_CNT);
        assign not_empty[s] = (count != '0);

        // No bypass: a full queue refuses even when it pops this cycle.
        assign src_ready[s] = reset & run & ~full[s];

        // Writes to x0 are accepted but never queued.
        assign push[s] = src_valid[s] & src_ready[s]
                       & (src_in[s].rd != 5'd0);

        assign head[s] = slots[rd_ptr];

        always_ff @(posedge clk) begin
            if (push[s]) begin
                slots[wr_ptr] <= src_in[s];
            end
        end

        // Pointers wrap naturally since DEPTH is a power of two.
        always_ff @(posedge clk) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[s]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop[s]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push[s], pop[s]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Round-robin on contention: MEM wins unless it was granted last.
    // last_mem resets to 0, which gives MEM priority after reset.
    assign grant_mem = not_empty[1] & (~not_empty[0] | ~last_mem);
    assign grant_alu = not_empty[0] & ~grant_mem;
    assign grant_any = grant_alu | grant_mem;
    assign pop       = {grant_mem, grant_alu};
    assign granted   = grant_mem ? head[1] : head[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            run       <= 1'b0;
            last_mem  <= 1'b0;
            write_sig <= 1'b0;
            write_reg <= 5'd0;
            write_val <= 64'd0;
        end else begin
            run <= 1'b1;
            if (grant_any) begin
                last_mem  <= grant_mem;
                write_sig <= 1'b1;
                write_reg <= granted.rd;
                write_val <= granted.val;
            end else begin
                write_sig <= 1'b0;
            end
        end
    end

    assign idle = ~not_empty[0] & ~not_empty[1] & ~write_sig;

`ifdef WB_COUNT_EN
    // Counts edges that load write_sig with 1; wraps at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_count <= 32'd0;
        end else if (grant_any) begin
            wb_count <= wb_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/writeback_arb.md
WRITEBACK_ARB -- requirements
Module: writeback_arb

Interface
REQ-001 Parameter DEPTH, default 2: entries per source queue; power of two, at least 2.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 alu_valid  in  1  ALU result offered.
REQ-005 alu_rd  in  5  ALU destination register.
REQ-006 alu_val  in  64  ALU result value.
REQ-007 alu_ready  out  1  ALU queue can accept; equals not-full of ALU queue.
REQ-008 mem_valid  in  1  load result offered.
REQ-009 mem_rd  in  5  load destination register.
REQ-010 mem_val  in  64  load result value.
REQ-011 mem_ready  out  1  MEM queue can accept; equals not-full of MEM queue.
REQ-012 write_sig  out  1  registered register-file write enable.
REQ-013 write_reg  out  5  registered register-file write index.
REQ-014 write_val  out  64  registered register-file write data.
REQ-015 idle  out  1  both queues empty and write_sig low.

Function
REQ-016 Transfer per source occurs on a rising edge where valid and ready are both high.
REQ-017 Transfer with rd != 0 enqueues {rd, val} into that source's FIFO queue of DEPTH entries.
REQ-018 Transfer with rd == 0 is accepted and discarded: no enqueue, no write ever issued.
REQ-019 ready depends only on queue occupancy, never on valid; a full queue drops ready even if a pop occurs in the same cycle (no bypass).
REQ-020 Arbiter grants at most one head entry per cycle, from queues non-empty at cycle start.
REQ-021 Only one queue non-empty: that queue is granted.
REQ-022 Both non-empty: round-robin; grant the source not granted last; after reset MEM has priority.
REQ-023 Granted entry pops on the next edge; on that same edge write_sig<=1, write_reg<=rd, write_val<=val.
REQ-024 No grant: write_sig<=0 on the edge; write_reg/write_val hold last values.
REQ-025 Latency: transfer on edge k into empty, uncontended queue gives write_sig high for the cycle after edge k+1.
REQ-026 Per source, writes leave in acceptance order; same-source WAW order preserved.
REQ-027 Simultaneous push and pop on one queue: occupancy unchanged, pointers both advance, wrap modulo DEPTH.
REQ-028 Occupancy counter width log2(DEPTH)+1; full = count==DEPTH, empty = count==0.
REQ-029 Sustained throughput: one write per cycle while any queue non-empty.

Reset
REQ-030 reset low on an edge: both queues emptied, pointers/counts 0, write_sig 0, write_reg 0, write_val 0, round-robin state = MEM priority.
REQ-031 During reset, alu_ready and mem_ready are 0; transfers presented are ignored.
REQ-032 Reset mid-operation discards all queued entries; no write_sig pulse follows the reset edge.
REQ-033 First edge with reset high: outputs remain reset values; ready rises combinationally after it.

Configuration
REQ-034 Macro WB_COUNT_EN defined: port wb_count out 32 counts edges with write_sig loaded 1; reset to 0; wraps 0xFFFFFFFF->0.
REQ-035 WB_COUNT_EN undefined: wb_count port and counter absent; all other behaviour identical.

Verification
REQ-036 Reset, then single ALU transfer rd=5 val=0x1234 -> write_sig=1, write_reg=5, write_val=0x1234 exactly one cycle, two edges after transfer.
REQ-037 Same edge ALU rd=1 val=0xA, MEM rd=2 val=0xB -> writes reg2=0xB then reg1=0xA on consecutive cycles.
REQ-038 Hold mem_valid, DEPTH=2, three transfers with no drain possible -> mem_ready low after 2; order preserved on drain.
REQ-039 Transfer rd=0 val=0xFF on either source -> accepted, no write_sig pulse, idle stays 1.
REQ-040 Fill both queues then assert reset low one edge -> write_sig 0, both ready 0 during reset, no stale writes afterward.
REQ-041 With WB_COUNT_EN, 5 committed writes -> wb_count=5; preload-free wrap check by forcing 0xFFFFFFFF then one write -> 0.
